// File: rtl/swu_stream.sv
// rtl/swu_stream.sv - sliding-window unit over a packed MSB-first ROM bit stream
//
// Reads DEPTH words of WORD_W bits from a synchronous ROM (1-cycle latency),
// treats them as one continuous MSB-first bit stream and emits WIN_W-bit
// windows every STRIDE bits under a valid/ready handshake.
//
// Ports:
//   i_clk        clock, all logic on the rising edge
//   i_rst        synchronous active-high reset
//   i_start      begin one pass (sampled only while idle)
//   o_mem_en     ROM read enable
//   o_mem_addr   ROM word address
//   i_mem_rdata  ROM data, one cycle after o_mem_en
//   o_win_data   current window, first stream bit in the MSB
//   o_win_valid  o_win_data is valid
//   i_win_ready  downstream accepts the window
//   o_busy       pass in progress
//   o_done       one-cycle pulse ending a pass
module swu_stream #(
    parameter int WORD_W = 32,
    parameter int WIN_W  = 7,
    parameter int STRIDE = 2,
    parameter int DEPTH  = 29,
    parameter int ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_mem_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [WORD_W-1:0] i_mem_rdata,
    output logic [WIN_W-1:0]  o_win_data,
    output logic              o_win_valid,
    input  logic              i_win_ready,
    output logic              o_busy,
    output logic              o_done
);
    // One word of slack beyond the two-cycle refill loop keeps a full-rate
    // stream even when every window consumes a whole word.
    localparam int BUF_W = WIN_W + 3 * WORD_W;
    localparam int CW    = $clog2(BUF_W + 1) + 2;
    localparam int N     = (DEPTH * WORD_W - WIN_W) / STRIDE + 1;
    localparam int XW    = $clog2(N + 1);
    localparam int RW    = ADDR_W + 1;
    // A window that will be followed by another must also cover the stride
    // so the pop on its transfer never runs past the valid bits.
    localparam int MAXWS = (WIN_W > STRIDE) ? WIN_W : STRIDE;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

    state_t            r_state;
    logic [BUF_W-1:0]  r_buf;       // valid bits left-aligned, current window at the top
    logic [CW-1:0]     r_cnt;
    logic              r_rvalid;    // read issued last cycle, data on i_mem_rdata now
    logic              r_mem_en;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [RW-1:0]     r_rd_cnt;    // words requested this pass
    logic [XW-1:0]     r_xfer_cnt;
    logic [WIN_W-1:0]  r_win_data;
    logic              r_win_valid;
    logic              r_busy;
    logic              r_done;

    logic              w_xfer;
    logic              w_last_xfer;
    logic              w_active;
    logic [CW-1:0]     w_cnt_pop;
    logic [CW-1:0]     w_cnt_next;
    logic [CW-1:0]     w_need;
    logic [BUF_W-1:0]  w_buf_pop;
    logic [BUF_W-1:0]  w_buf_next;
    logic [BUF_W-1:0]  w_word_ext;
    logic [XW-1:0]     w_xfer_next;
    logic              w_load;
    logic              w_fetch;

    always_comb begin
        w_active    = (r_state == S_FILL) || (r_state == S_RUN);
        w_xfer      = r_win_valid && i_win_ready;
        w_last_xfer = w_xfer && (r_xfer_cnt == XW'(N - 1));
        w_cnt_pop   = w_xfer ? (r_cnt - CW'(STRIDE)) : r_cnt;
        w_buf_pop   = w_xfer ? (r_buf << STRIDE) : r_buf;
        // Arriving word lands directly behind the last valid bit.
        w_word_ext  = {i_mem_rdata, {(BUF_W - WORD_W){1'b0}}};
        w_buf_next  = w_buf_pop | (r_rvalid ? (w_word_ext >> w_cnt_pop) : '0);
        w_cnt_next  = w_cnt_pop + (r_rvalid ? CW'(WORD_W) : '0);
        w_xfer_next = r_xfer_cnt + XW'(w_xfer);
        w_need      = (w_xfer_next == XW'(N - 1)) ? CW'(WIN_W) : CW'(MAXWS);
        w_load      = w_active && (!r_win_valid || w_xfer) && !w_last_xfer
                      && (w_cnt_next >= w_need);
        // Reserve room for the read already in flight plus the new one,
        // ignoring pops so a stalled consumer can never overflow the buffer.
        w_fetch     = w_active && (r_rd_cnt < RW'(DEPTH))
                      && ((w_cnt_next + (r_mem_en ? CW'(WORD_W) : '0) + CW'(WORD_W))
                          <= CW'(BUF_W));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_buf       <= '0;
            r_cnt       <= '0;
            r_rvalid    <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_addr  <= '0;
            r_rd_cnt    <= '0;
            r_xfer_cnt  <= '0;
            r_win_data  <= '0;
            r_win_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done   <= 1'b0;
                    r_rvalid <= 1'b0;
                    if (i_start) begin
                        r_state    <= S_FILL;
                        r_busy     <= 1'b1;
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= '0;
                        r_rd_cnt   <= RW'(1);
                        r_buf      <= '0;
                        r_cnt      <= '0;
                        r_xfer_cnt <= '0;
                    end else begin
                        r_mem_en <= 1'b0;
                    end
                end
                S_FILL, S_RUN: begin
                    r_rvalid   <= r_mem_en;
                    r_mem_en   <= w_fetch;
                    if (w_fetch) begin
                        r_mem_addr <= r_rd_cnt[ADDR_W-1:0];
                        r_rd_cnt   <= r_rd_cnt + RW'(1);
                    end
                    r_buf      <= w_buf_next;
                    r_cnt      <= w_cnt_next;
                    r_xfer_cnt <= w_xfer_next;
                    if (w_last_xfer) begin
                        r_state     <= S_DONE;
                        r_win_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_cnt       <= '0;
                    end else if (w_load) begin
                        r_win_data  <= w_buf_next[BUF_W-1 -: WIN_W];
                        r_win_valid <= 1'b1;
                        r_state     <= S_RUN;
                    end else if (w_xfer) begin
                        r_win_valid <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_done   <= 1'b0;
                    r_mem_en <= 1'b0;
                    r_rvalid <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_mem_en    = r_mem_en;
    assign o_mem_addr  = r_mem_addr;
    assign o_win_data  = r_win_data;
    assign o_win_valid = r_win_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
endmodule

// File: tb/tb_swu_stream.sv
// tb/tb_swu_stream.sv - self-checking bench for swu_stream
module tb_swu_stream;
    localparam int N = (29 * 32 - 7) / 2 + 1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, mem_en, win_valid, win_ready, busy, done;
    logic [4:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic [6:0]  win_data;

    logic        start2, mem_en2, win_valid2, win_ready2, busy2, done2;
    logic [1:0]  mem_addr2;
    logic [15:0] mem_rdata2, win_data2;

    logic [31:0] rom [29];
    logic [15:0] rom2 [4];
    int          rd_count [29];
    int          bad_addr;
    logic [6:0]  got [$];
    int          checks = 0;
    int          failures = 0;

    swu_stream u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .o_mem_en(mem_en),
        .o_mem_addr(mem_addr), .i_mem_rdata(mem_rdata), .o_win_data(win_data),
        .o_win_valid(win_valid), .i_win_ready(win_ready), .o_busy(busy), .o_done(done)
    );

    swu_stream #(.WORD_W(16), .WIN_W(16), .STRIDE(16), .DEPTH(4), .ADDR_W(2)) u_alt (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .o_mem_en(mem_en2),
        .o_mem_addr(mem_addr2), .i_mem_rdata(mem_rdata2), .o_win_data(win_data2),
        .o_win_valid(win_valid2), .i_win_ready(win_ready2), .o_busy(busy2), .o_done(done2)
    );

    always @(posedge clk) begin
        if (mem_en && mem_addr < 5'd29) mem_rdata <= rom[mem_addr];
        if (mem_en2) mem_rdata2 <= rom2[mem_addr2];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Window k straight from the stream definition: bit i lives in word i/32,
    // at bit position 31-(i%32); the first stream bit becomes the MSB.
    function automatic logic [6:0] window_exp(input int k);
        logic [6:0]  r;
        logic [31:0] w;
        int          i;
        for (int b = 0; b < 7; b++) begin
            i = k * 2 + b;
            w = rom[i / 32];
            r[6 - b] = w[31 - (i % 32)];
        end
        return r;
    endfunction

    // rmode 0: ready held high; 1: random ready with a 5-cycle stall on window 100.
    task automatic run_pass(input int rmode, input bit pulse, input int rst_at);
        int c, stall, first_v, last_x, busy_bad, hold_bad, mism, not_once;
        bit fin, prev_hold;
        logic [6:0] prev_data;
        got.delete();
        for (int a = 0; a < 29; a++) rd_count[a] = 0;
        bad_addr = 0; stall = 0; first_v = -1; last_x = -1;
        busy_bad = 0; hold_bad = 0; fin = 0; prev_hold = 0; prev_data = '0;
        start = 1'b1; win_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; c = 1;
        check("start_busy", busy, 1);
        check("start_mem_en", mem_en, 1);
        check("start_mem_addr", mem_addr, 0);
        while (!fin && c < 5000) begin
            if (mem_en) begin
                if (mem_addr < 5'd29) rd_count[mem_addr]++;
                else bad_addr++;
            end
            if (prev_hold && (!win_valid || win_data !== prev_data)) hold_bad++;
            if (rst_at >= 0 && got.size() == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check("rst_mid_outputs", {win_data, win_valid, busy, done, mem_en, mem_addr}, 0);
                return;
            end
            if (done) begin
                fin = 1;
            end else begin
                if (!busy) busy_bad++;
                if (rmode == 1 && win_valid && got.size() == 100 && stall < 5) begin
                    win_ready = 1'b0;
                    stall++;
                end else begin
                    win_ready = (rmode == 0) ? 1'b1 : 1'($urandom % 2);
                end
                if (win_valid && first_v < 0) first_v = c;
                if (win_valid && win_ready) begin
                    got.push_back(win_data);
                    last_x = c;
                end
                prev_hold = win_valid && !win_ready;
                prev_data = win_data;
                start = pulse && (c == 50);
                @(posedge clk); #1;
                c++;
            end
        end
        check("pass_terminated", fin, 1);
        if (fin) begin
            check("done_after_last", c, last_x + 1);
            check("done_valid_low", win_valid, 0);
            check("done_busy_low", busy, 0);
            start = pulse;
            @(posedge clk); #1;
            start = 1'b0;
            check("done_one_cycle", done, 0);
            if (pulse) check("start_in_done_ignored", busy, 0);
        end
        check("first_valid_latency", first_v, 3);
        check("window_count", got.size(), N);
        if (rmode == 0) check("last_window_cycle", last_x, 3 + N - 1);
        if (rmode == 1) check("stall_cycles", stall, 5);
        check("busy_held", busy_bad, 0);
        check("hold_stable", hold_bad, 0);
        mism = 0;
        for (int i = 0; i < got.size() && i < N; i++) begin
            if (got[i] !== window_exp(i)) begin
                if (mism == 0)
                    $display("FAIL window_%0d actual=%0h required=%0h", i, got[i], window_exp(i));
                mism++;
            end
        end
        check("window_seq_mismatches", mism, 0);
        not_once = 0;
        for (int a = 0; a < 29; a++) if (rd_count[a] != 1) not_once++;
        check("reads_not_once", not_once, 0);
        check("addr_out_of_range", bad_addr, 0);
    endtask

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        int          idx;
        logic [6:0]  exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int c, last2;
        bit fin2;
        logic [15:0] got2 [$];

        vecs[0] = '{32'hFE00_0000, 32'h0, 0,  7'h7F};
        vecs[1] = '{32'hFE00_0000, 32'h0, 1,  7'h7C};
        vecs[2] = '{32'hFE00_0000, 32'h0, 2,  7'h70};
        vecs[3] = '{32'hFE00_0000, 32'h0, 3,  7'h40};
        vecs[4] = '{32'hFE00_0000, 32'h0, 4,  7'h00};
        vecs[5] = '{32'h0000_003F, 32'h8000_0000, 12, 7'h1F};
        vecs[6] = '{32'h0000_003F, 32'h8000_0000, 13, 7'h7F};
        vecs[7] = '{32'h0000_003F, 32'h8000_0000, 14, 7'h7C};
        vecs[8] = '{32'h0000_003F, 32'h8000_0000, 15, 7'h70};
        vecs[9] = '{32'h0000_003F, 32'h8000_0000, 16, 7'h40};

        rst = 1'b1; start = 1'b0; win_ready = 1'b1; start2 = 1'b0; win_ready2 = 1'b1;
        for (int a = 0; a < 29; a++) rom[a] = '0;
        for (int a = 0; a < 4; a++) rom2[a] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {win_data, win_valid, busy, done, mem_en, mem_addr}, 0);
        check("reset_alt_outputs", {win_data2, win_valid2, busy2, done2, mem_en2, mem_addr2}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            if (i == 0 || vecs[i].w0 != vecs[i-1].w0 || vecs[i].w1 != vecs[i-1].w1) begin
                for (int a = 0; a < 29; a++) rom[a] = '0;
                rom[0] = vecs[i].w0;
                rom[1] = vecs[i].w1;
                run_pass(0, 0, -1);
            end
            check($sformatf("vec%0d_window_%0d", i, vecs[i].idx),
                  (got.size() > vecs[i].idx) ? got[vecs[i].idx] : 7'bx, vecs[i].exp);
        end

        for (int a = 0; a < 29; a++) rom[a] = $urandom;
        run_pass(0, 0, -1);
        run_pass(1, 0, -1);
        for (int a = 0; a < 29; a++) rom[a] = $urandom;
        run_pass(0, 1, -1);
        run_pass(0, 0, 200);
        run_pass(0, 0, -1);

        for (int a = 0; a < 4; a++) rom2[a] = 16'($urandom);
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0; c = 1; fin2 = 0; last2 = -1;
        while (!fin2 && c < 100) begin
            if (done2) begin
                fin2 = 1;
            end else begin
                if (win_valid2) begin
                    got2.push_back(win_data2);
                    last2 = c;
                end
                @(posedge clk); #1;
                c++;
            end
        end
        check("alt_terminated", fin2, 1);
        check("alt_count", got2.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("alt_window_%0d", i), (got2.size() > i) ? got2[i] : 16'bx, rom2[i]);
        check("alt_done_after_last", c, last2 + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
